// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader and its word assembler.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int DEFAULT_DEPTH  = 21;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RECV  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects bytes little-endian into a 32-bit word; flags the byte that completes it.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        complete
);

  logic [IDX_W-1:0] idx_q;
  logic [31:0]      word_q;

  // word already contains the byte being accepted this cycle
  always_comb begin
    word = word_q;
    if (accept) begin
      word[{idx_q, 3'b000} +: 8] = byte_in;
    end
  end

  assign complete = accept && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (accept) begin
      idx_q  <= idx_q + IDX_W'(1);
      word_q <= word;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams bytes into instruction memory: clear pulse, then one write per assembled word.
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
module program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             instruction_reset,
  output logic             write_signal,
  output logic [31:0]      write_address,
  output logic [31:0]      instruction_write,
  output logic             busy,
  output logic             done,
  output logic             error,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] count_q, addr_q, addr_inc, wa_q;
  logic [31:0]      iw_q;
  logic             error_q;
  logic             asm_clear, asm_accept, asm_complete;
  logic [31:0]      asm_word;

  assign asm_clear  = (state_q == CLEAR);
  assign asm_accept = (state_q == RECV) && byte_valid;
  assign addr_inc   = addr_q + CNT_W'(1);

  word_assembler u_asm (
    .clk      (clk),
    .rst      (reset),
    .clear    (asm_clear),
    .accept   (asm_accept),
    .byte_in  (byte_in),
    .word     (asm_word),
    .complete (asm_complete)
  );

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count == '0)          state_n = DONE;
          else if (word_count <= DEPTH_C) state_n = CLEAR;
        end
      end
      CLEAR:   state_n = RECV;
      RECV:    if (asm_complete) state_n = WRITE;
      WRITE:   state_n = (addr_inc == count_q) ? DONE : RECV;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wa_q    <= '0;
      iw_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_q == IDLE && start && word_count != '0) begin
        if (word_count > DEPTH_C) begin
          error_q <= 1'b1;
        end else begin
          error_q <= 1'b0;
          count_q <= word_count;
        end
      end
      if (state_q == CLEAR) addr_q <= '0;
      if (state_q == WRITE) addr_q <= addr_inc;
      // capture the write port contents as the final byte lands; they hold through DONE
      if (asm_complete) begin
        wa_q <= addr_q;
        iw_q <= asm_word;
      end
    end
  end

  assign byte_ready        = (state_q == RECV);
  assign instruction_reset = (state_q == CLEAR);
  assign write_signal      = (state_q == WRITE);
  assign busy              = (state_q == CLEAR) || (state_q == RECV) || (state_q == WRITE);
  assign done              = (state_q == DONE);
  assign error             = error_q;
  assign write_address     = 32'(wa_q);
  assign instruction_write = iw_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: driver tasks, write scoreboard, model memory.
module tb_program_loader;

  localparam int DEPTH = 21;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] word_count = '0;
  logic [7:0]       byte_in = '0;
  logic             byte_valid = 1'b0;
  logic             byte_ready, instruction_reset, write_signal, busy, done, error;
  logic [31:0]      write_address, instruction_write;
  logic [2:0]       dbg_state;

  program_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .word_count        (word_count),
    .byte_in           (byte_in),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .instruction_reset (instruction_reset),
    .write_signal      (write_signal),
    .write_address     (write_address),
    .instruction_write (instruction_write),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // scoreboard state
  logic [63:0] exp_q[$];
  logic [31:0] dut_mem [0:31];
  logic [31:0] model_mem [0:31];
  int n_pass = 0, n_total = 0;
  int clear_cnt = 0, write_cnt = 0, done_cnt = 0;
  int last_clear_cyc = 0, last_done_cyc = 0, start_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // compare process
  always @(negedge clk) begin
    logic [63:0] e;
    if (instruction_reset || write_signal)
      chk("clear_write_exclusive", 64'(instruction_reset & write_signal), 64'd0);
    if (byte_ready) chk("ready_implies_busy", 64'(busy), 64'd1);
    if (instruction_reset) begin
      clear_cnt++;
      last_clear_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
      chk("done_not_busy", 64'(busy), 64'd0);
    end
    if (write_signal) begin
      write_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_address", 64'(write_address), 64'(e[63:32]));
        chk("write_data", 64'(instruction_write), 64'(e[31:0]));
      end
      dut_mem[write_address[4:0]] = instruction_write;
    end
  end

  // driver tasks
  task automatic start_load(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    word_count = CNT_W'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    word_count = CNT_W'($urandom_range(0, 31));
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int k;
    int gap;
    gap = $urandom_range(0, max_gap);
    repeat (gap) begin
      byte_in = 8'($urandom);
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_in = b;
    k = 0;
    @(negedge clk);
    while (!byte_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!byte_ready) chk("byte_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
  endtask

  task automatic send_word(input int addr, input logic [31:0] w, input int max_gap);
    exp_q.push_back({32'(addr), w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap);
  endtask

  task automatic wait_done(input int prev);
    int k = 0;
    while (done_cnt == prev && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    if (done_cnt == prev) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    chk({tag, "_instruction_reset"}, 64'(instruction_reset), 64'd0);
    chk({tag, "_write_signal"}, 64'(write_signal), 64'd0);
    chk({tag, "_write_address"}, 64'(write_address), 64'd0);
    chk({tag, "_instruction_write"}, 64'(instruction_write), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    logic [7:0]  t1b [8];
    logic [31:0] w;
    int d0, c0, w0;

    t1b = '{8'h13, 8'h00, 8'h10, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;

    // known two-word program, back-to-back bytes
    d0 = done_cnt; c0 = clear_cnt; w0 = write_cnt;
    exp_q.push_back({32'd0, 32'h00100013});
    exp_q.push_back({32'd1, 32'h002080B3});
    start_load(2);
    for (int i = 0; i < 8; i++) send_byte(t1b[i], 0);
    wait_done(d0);
    chk("t1_done_latency", 64'(last_done_cyc - start_cyc), 64'd12);
    chk("t1_clear_latency", 64'(last_clear_cyc - start_cyc), 64'd1);
    chk("t1_clear_count", 64'(clear_cnt - c0), 64'd1);
    chk("t1_write_count", 64'(write_cnt - w0), 64'd2);
    chk("t1_hold_address", 64'(write_address), 64'd1);
    chk("t1_hold_data", 64'(instruction_write), 64'h002080B3);

    // full-depth load with random bytes and gaps
    for (int a = 0; a < 32; a++) dut_mem[a] = 32'hDEADBEEF;
    d0 = done_cnt; c0 = clear_cnt; w0 = write_cnt;
    start_load(DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      w = $urandom;
      model_mem[a] = w;
      send_word(a, w, 3);
    end
    wait_done(d0);
    chk("t2_clear_count", 64'(clear_cnt - c0), 64'd1);
    chk("t2_write_count", 64'(write_cnt - w0), 64'(DEPTH));
    for (int a = 0; a < DEPTH; a++) chk("t2_mem", 64'(dut_mem[a]), 64'(model_mem[a]));

    // oversize count rejected, then a valid start clears error
    c0 = clear_cnt; w0 = write_cnt;
    start_load(DEPTH + 1);
    repeat (10) @(negedge clk);
    chk("t3_error_set", 64'(error), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_no_clear", 64'(clear_cnt - c0), 64'd0);
    chk("t3_no_write", 64'(write_cnt - w0), 64'd0);
    d0 = done_cnt;
    start_load(1);
    chk("t3_error_cleared", 64'(error), 64'd0);
    send_word(0, $urandom, 2);
    wait_done(d0);
    chk("t3_error_after", 64'(error), 64'd0);

    // zero-length load
    d0 = done_cnt; c0 = clear_cnt; w0 = write_cnt;
    start_load(0);
    wait_done(d0);
    chk("t4_done_latency", 64'(last_done_cyc - start_cyc), 64'd1);
    chk("t4_no_clear", 64'(clear_cnt - c0), 64'd0);
    chk("t4_no_write", 64'(write_cnt - w0), 64'd0);

    // reset in the middle of word 1 of a 3-word load
    d0 = done_cnt;
    start_load(3);
    send_word(0, $urandom, 1);
    w = $urandom;
    send_byte(w[7:0], 1);
    send_byte(w[15:8], 1);
    #2;
    reset = 1'b1;
    #1;
    chk_outputs_zero("t5_mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t5_scoreboard_drained", 64'(exp_q.size()), 64'd0);
    start_load(1);
    send_word(0, $urandom, 0);
    wait_done(d0);
    chk("t5_done_count", 64'(done_cnt - d0), 64'd1);

    // start during RECV with another count is ignored
    d0 = done_cnt; w0 = write_cnt;
    start_load(2);
    w = $urandom;
    exp_q.push_back({32'd0, w});
    send_byte(w[7:0], 0);
    send_byte(w[15:8], 0);
    @(posedge clk); #1;
    start = 1'b1;
    word_count = CNT_W'(7);
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(w[23:16], 0);
    send_byte(w[31:24], 0);
    send_word(1, $urandom, 2);
    wait_done(d0);
    repeat (20) @(negedge clk);
    chk("t6_write_count", 64'(write_cnt - w0), 64'd2);
    chk("t6_busy_after", 64'(busy), 64'd0);
    chk("t6_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
